// File: rtl/otter_pipe_pkg.sv
// Shared OTTER pipeline types: hazard controller states and forwarding selects.
package otter_pipe_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } hz_state_t;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/otter_hazard_ctrl_if.sv
// Bundle between the OTTER datapath (master) and the hazard controller (slave).
interface otter_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       rs1_D;
   logic [4:0]       rs2_D;
   logic             use_rs1_D;
   logic             use_rs2_D;
   logic [4:0]       rs1_E;
   logic [4:0]       rs2_E;
   logic [4:0]       rd_E;
   logic             memRead2_E;
   logic             pcSource_E;
   logic [4:0]       rd_M;
   logic             regWrite_M;
   logic [4:0]       rd_W;
   logic             regWrite_W;

   logic             pcWrite_F;
   logic             ld_F_D;
   logic             flush_F_D;
   logic             flush_D_E;
   logic [1:0]       fwdA_E;
   logic [1:0]       fwdB_E;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output rs1_D, rs2_D, use_rs1_D, use_rs2_D,
      output rs1_E, rs2_E, rd_E, memRead2_E, pcSource_E,
      output rd_M, regWrite_M, rd_W, regWrite_W,
      input  pcWrite_F, ld_F_D, flush_F_D, flush_D_E,
      input  fwdA_E, fwdB_E, stall_cnt, flush_cnt
   );

   modport slave (
      input  rs1_D, rs2_D, use_rs1_D, use_rs2_D,
      input  rs1_E, rs2_E, rd_E, memRead2_E, pcSource_E,
      input  rd_M, regWrite_M, rd_W, regWrite_W,
      output pcWrite_F, ld_F_D, flush_F_D, flush_D_E,
      output fwdA_E, fwdB_E, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/otter_fwd_unit.sv
// Execute-stage operand forwarding compare; Memory-stage result beats Writeback.
module otter_fwd_unit
   import otter_pipe_pkg::*;
(
   input  logic [4:0] i_rs1_E,
   input  logic [4:0] i_rs2_E,
   input  logic [4:0] i_rd_M,
   input  logic       i_regWrite_M,
   input  logic [4:0] i_rd_W,
   input  logic       i_regWrite_W,
   output logic [1:0] o_fwdA_E,
   output logic [1:0] o_fwdB_E
);

   logic [4:0] w_rs  [2];
   logic [1:0] w_sel [2];

   assign w_rs[0] = i_rs1_E;
   assign w_rs[1] = i_rs2_E;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_operand
         logic w_hit_m;
         logic w_hit_w;

         // x0 is hard-wired zero, so a pending write to it is never forwarded.
         assign w_hit_m = i_regWrite_M && (i_rd_M != 5'd0) && (i_rd_M == w_rs[gi]);
         assign w_hit_w = i_regWrite_W && (i_rd_W != 5'd0) && (i_rd_W == w_rs[gi]);

         assign w_sel[gi] = w_hit_m ? FWD_MEM :
                            w_hit_w ? FWD_WB  : FWD_REG;
      end
   endgenerate

   assign o_fwdA_E = w_sel[0];
   assign o_fwdB_E = w_sel[1];

endmodule

// File: rtl/otter_hazard_ctrl.sv
// OTTER 5-stage hazard/sequencing controller: fill after reset, load-use stall,
// redirect flush, operand forwarding and saturating event counters.
module otter_hazard_ctrl
   import otter_pipe_pkg::*;
#(
   parameter int FILL_CYCLES  = 1,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
)(
   input  logic               CLK,
   input  logic               RESET_N,
   otter_hazard_ctrl_if.slave bus
);

   localparam logic [2:0] FILL_INIT  = 3'(FILL_CYCLES);
   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

   hz_state_t        r_state;
   hz_state_t        w_state_next;
   logic [2:0]       r_cyc_cnt;
   logic [2:0]       w_cyc_next;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_load_use;
   logic             w_pc_wr;
   logic             w_ld_fd;
   logic             w_fl_fd;
   logic             w_fl_de;
   logic             w_stall_inc;
   logic             w_flush_inc;
   logic [1:0]       w_fwdA;
   logic [1:0]       w_fwdB;

   // A load writing x0 produces nothing to wait for, so it never stalls.
   assign w_load_use = bus.memRead2_E && (bus.rd_E != 5'd0) &&
                       ((bus.use_rs1_D && (bus.rs1_D == bus.rd_E)) ||
                        (bus.use_rs2_D && (bus.rs2_D == bus.rd_E)));

   always_comb begin
      w_state_next = r_state;
      w_cyc_next   = r_cyc_cnt;
      w_pc_wr      = 1'b1;
      w_ld_fd      = 1'b1;
      w_fl_fd      = 1'b0;
      w_fl_de      = 1'b0;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;

      case (r_state)
         FILL: begin
            w_fl_fd    = 1'b1;
            w_fl_de    = 1'b1;
            w_cyc_next = r_cyc_cnt - 3'd1;
            if (r_cyc_cnt <= 3'd1) begin
               w_state_next = RUN;
            end
         end

         RUN: begin
            if (bus.pcSource_E) begin
               w_fl_fd     = 1'b1;
               w_fl_de     = 1'b1;
               w_flush_inc = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  w_state_next = FLUSH;
                  w_cyc_next   = FLUSH_INIT;
               end
            end else if (w_load_use) begin
               // One-cycle stall: the load moves on to M and the hazard clears.
               w_pc_wr     = 1'b0;
               w_ld_fd     = 1'b0;
               w_fl_de     = 1'b1;
               w_stall_inc = 1'b1;
            end
         end

         FLUSH: begin
            // D/E already holds a bubble from the redirect cycle.
            w_fl_fd    = 1'b1;
            w_cyc_next = r_cyc_cnt - 3'd1;
            if (r_cyc_cnt <= 3'd1) begin
               w_state_next = RUN;
            end
         end

         default: begin
            w_fl_fd      = 1'b1;
            w_fl_de      = 1'b1;
            w_state_next = FILL;
            w_cyc_next   = FILL_INIT;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= FILL;
         r_cyc_cnt   <= FILL_INIT;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         r_state   <= w_state_next;
         r_cyc_cnt <= w_cyc_next;
         if (w_stall_inc && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_flush_inc && !(&r_flush_cnt)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   otter_fwd_unit u_fwd (
      .i_rs1_E      (bus.rs1_E),
      .i_rs2_E      (bus.rs2_E),
      .i_rd_M       (bus.rd_M),
      .i_regWrite_M (bus.regWrite_M),
      .i_rd_W       (bus.rd_W),
      .i_regWrite_W (bus.regWrite_W),
      .o_fwdA_E     (w_fwdA),
      .o_fwdB_E     (w_fwdB)
   );

   // Reset forces a frozen, fully bubbled pipeline without waiting for a clock.
   assign bus.pcWrite_F = RESET_N & w_pc_wr;
   assign bus.ld_F_D    = RESET_N & w_ld_fd;
   assign bus.flush_F_D = ~RESET_N | w_fl_fd;
   assign bus.flush_D_E = ~RESET_N | w_fl_de;
   assign bus.fwdA_E    = RESET_N ? w_fwdA : FWD_REG;
   assign bus.fwdB_E    = RESET_N ? w_fwdB : FWD_REG;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: doc/otter_hazard_ctrl.md
Name: otter_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipelined OTTER (Fetch, Decode, Execute, Memory, Writeback). It performs four jobs:
- Drives the PC write enable and the F/D load enable.
- Drives the F/D and D/E flush (bubble) controls.
- Drives the Execute-stage operand forwarding selects.
- Keeps saturating stall and flush event counters.
It sequences the pipeline after reset (instruction-memory read latency fill), on load-use hazards, and on taken branch/jump redirects from Execute.

Parameters:
- FILL_CYCLES, 1, cycles of F/D flush after reset release to cover synchronous instruction-memory latency (1..7).
- FLUSH_CYCLES, 2, total cycles F/D is flushed per redirect, including the detecting cycle (1..7).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- rs1_D  in  5  Decode rs1 address (Instr_D[19:15]).
- rs2_D  in  5  Decode rs2 address (Instr_D[24:20]).
- use_rs1_D  in  1  Decode instruction reads rs1.
- use_rs2_D  in  1  Decode instruction reads rs2.
- rs1_E  in  5  Execute rs1 address.
- rs2_E  in  5  Execute rs2 address.
- rd_E  in  5  Execute destination.
- memRead2_E  in  1  Execute instruction is a load.
- pcSource_E  in  1  taken branch/jump resolved in Execute.
- rd_M  in  5  Memory destination.
- regWrite_M  in  1  Memory writes the register file.
- rd_W  in  5  Writeback destination.
- regWrite_W  in  1  Writeback writes the register file.
- pcWrite_F  out  1  PC register load enable.
- ld_F_D  out  1  F/D pipeline register load enable.
- flush_F_D  out  1  F/D register loads a NOP bubble.
- flush_D_E  out  1  D/E register loads a bubble (all control bits 0).
- fwdA_E  out  2  ALU srcA select: 00 rs1_E, 01 ALU_result_M, 10 rf_write_data_W.
- fwdB_E  out  2  ALU srcB / store-data select, same encoding as fwdA_E.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  redirects taken, saturating.

Behaviour:
- FSM states: FILL, RUN, FLUSH. Separate down-counter cyc_cnt, 3 bits.
- Reset (RESET_N low, asynchronous):
  - state=FILL, cyc_cnt=FILL_CYCLES, stall_cnt=0, flush_cnt=0.
  - While RESET_N is low, outputs are forced: pcWrite_F=0, ld_F_D=0, flush_F_D=1, flush_D_E=1, fwdA_E=fwdB_E=00.
  - Reset asserted mid-FLUSH or mid-stall aborts immediately; no state survives.
- FILL:
  - Outputs: pcWrite_F=1, ld_F_D=1, flush_F_D=1, flush_D_E=1.
  - cyc_cnt decrements each cycle; when cyc_cnt==1, next state is RUN.
  - pcSource_E and load-use are ignored.
- RUN, redirect (pcSource_E=1; has priority over load-use):
  - Outputs: pcWrite_F=1, ld_F_D=1, flush_F_D=1, flush_D_E=1.
  - flush_cnt+=1.
  - If FLUSH_CYCLES>1: next state FLUSH with cyc_cnt=FLUSH_CYCLES-1. Otherwise stay in RUN.
- RUN, load-use hazard:
  - Condition: memRead2_E & rd_E!=0 & ((use_rs1_D & rs1_D==rd_E) | (use_rs2_D & rs2_D==rd_E)).
  - Outputs: pcWrite_F=0, ld_F_D=0, flush_F_D=0, flush_D_E=1; stall_cnt+=1.
  - The stall is exactly 1 cycle, because the load advances to M and the hazard clears. Load to x0 never stalls.
- RUN, otherwise: pcWrite_F=1, ld_F_D=1, both flushes 0.
- FLUSH:
  - Outputs: pcWrite_F=1, ld_F_D=1, flush_F_D=1, flush_D_E=0.
  - cyc_cnt decrements; cyc_cnt==1 leads to RUN.
  - pcSource_E and load-use are ignored, because E/D hold bubbles.
- Forwarding (combinational, every state, gated only by reset):
  - fwdA_E=01 if regWrite_M & rd_M!=0 & rd_M==rs1_E.
  - Else fwdA_E=10 if regWrite_W & rd_W!=0 & rd_W==rs1_E.
  - Else fwdA_E=00.
  - fwdB_E follows the same rule with rs2_E. M has priority over W when both match.
- Counters saturate at all-ones and never wrap. Counters update on the rising edge only.
- Outputs other than the counters are combinational from state and inputs. The state and counters are registered.

Decomposition:
- Shared package otter_pipe_pkg holds:
  - typedef enum logic [1:0] {FILL, RUN, FLUSH} hz_state_t.
  - localparams FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
- One natural sub-module: otter_fwd_unit, the purely combinational forwarding compare, instanced once with per-operand logic inside.
- The FSM and counters stay in otter_hazard_ctrl.

Test Plan:
- Reset release:
  - Stimulus: hold RESET_N low for 3 cycles, release, FILL_CYCLES=1.
  - Response: during reset pcWrite_F=0, flush_F_D=1. The cycle after release has flush_F_D=1 and pcWrite_F=1, followed by RUN with flushes 0.
- Load-use:
  - Stimulus: memRead2_E=1, rd_E=5, rs1_D=5, use_rs1_D=1 in RUN.
  - Response: one cycle of pcWrite_F=0, ld_F_D=0, flush_D_E=1, and stall_cnt goes 0 to 1. The same case with rd_E=0 gives no stall.
- Redirect:
  - Stimulus: pcSource_E=1 in RUN while a load-use condition is also true, FLUSH_CYCLES=2.
  - Response: cycle t has flush_F_D=1, flush_D_E=1, pcWrite_F=1. Cycle t+1 has flush_F_D=1, flush_D_E=0. stall_cnt is unchanged and flush_cnt=1.
- Forwarding:
  - Stimulus: rs1_E=rs2_E=7, rd_M=rd_W=7, regWrite_M=regWrite_W=1.
  - Response: fwdA_E=fwdB_E=01. With regWrite_M=0 the response is 10. With rd=0 the response is 00.
- Saturation and async reset:
  - Stimulus: CNT_W=4 with 20 load-use stalls; then pull RESET_N low mid-FLUSH.
  - Response: stall_cnt holds at 15. On reset, outputs go to reset values within the same cycle, and after release the sequence restarts in FILL.
